// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, datapath widths and the ID/EX held-instruction record
package alu_pkg;
  localparam int XLEN = 32;
  localparam int RAW = 5;
  typedef enum logic [2:0] {
    XOR = 3'b000,
    OR  = 3'b001,
    ADD = 3'b010,
    SUB = 3'b110
  } alu_op_t;
  typedef struct packed {
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    alu_op_t         alu_op;
    logic [RAW-1:0]  rd;
    logic            reg_write;
    logic            is_branch;
  } id_ex_t;
endpackage

// File: rtl/operand_fwd.sv
// operand_fwd: picks the youngest in-flight result for one source register, x0 excluded
module operand_fwd #(
  parameter int XLEN = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0]  rs,
  input  logic [XLEN-1:0] held,
  input  logic            exm_valid,
  input  logic [RAW-1:0]  exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_valid,
  input  logic [RAW-1:0]  mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] val,
  output logic            mwb_hit
);
  logic exm_hit;
  assign exm_hit = exm_valid && exm_rd == rs && rs != '0;
  assign mwb_hit = !exm_hit && mwb_valid && mwb_rd == rs && rs != '0;
  assign val = exm_hit ? exm_data : mwb_hit ? mwb_data : held;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: handshaked ID/EX register feeding the ALU with forwarded operands
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RAW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_alu_op,
  input  logic [RAW-1:0]  in_rd,
  input  logic            in_reg_write,
  input  logic            in_is_branch,
  input  logic            flush,
  input  logic            exm_valid,
  input  logic [RAW-1:0]  exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            mwb_valid,
  input  logic [RAW-1:0]  mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [RAW-1:0]  out_rd,
  output logic            out_reg_write,
  output logic            out_is_branch
);
  import alu_pkg::*;
  logic valid_q, valid_d;
  id_ex_t ex_q, ex_d;
  logic [XLEN-1:0] fwd1, fwd2;
  logic hit1, hit2, capture;
  operand_fwd #(.XLEN(XLEN), .RAW(RAW)) u_fwd1 (
    .rs(ex_q.rs1), .held(ex_q.op1),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_valid(mwb_valid), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .val(fwd1), .mwb_hit(hit1)
  );
  operand_fwd #(.XLEN(XLEN), .RAW(RAW)) u_fwd2 (
    .rs(ex_q.rs2), .held(ex_q.op2),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_valid(mwb_valid), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .val(fwd2), .mwb_hit(hit2)
  );
  assign in_ready = !valid_q || out_ready;
  assign capture = in_valid && in_ready && !flush;
  assign out_valid = valid_q;
  assign alu_a = fwd1;
  assign alu_b = ex_q.use_imm ? ex_q.imm : fwd2;
  assign out_rs2_val = fwd2;
  assign alu_op = ex_q.alu_op;
  assign out_rd = ex_q.rd;
  assign out_reg_write = ex_q.reg_write;
  assign out_is_branch = ex_q.is_branch;
  // flush kills, capture loads, drain clears; a stalled op keeps MEM/WB results before they retire
  always_comb begin
    valid_d = valid_q;
    ex_d = ex_q;
    if (flush) valid_d = 1'b0;
    else if (capture) begin
      valid_d = 1'b1;
      ex_d = '{rs1: in_rs1, rs2: in_rs2, op1: in_rs1_data, op2: in_rs2_data, imm: in_imm,
               use_imm: in_use_imm, alu_op: alu_op_t'(in_alu_op), rd: in_rd,
               reg_write: in_reg_write, is_branch: in_is_branch};
    end else if (valid_q && out_ready) valid_d = 1'b0;
    else if (valid_q) begin
      ex_d.op1 = hit1 ? fwd1 : ex_q.op1;
      ex_d.op2 = hit2 ? fwd2 : ex_q.op2;
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q <= ex_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of handshake, forwarding, stall refresh and flush
module tb_id_ex_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic in_use_imm = 1'b0, in_reg_write = 1'b0, in_is_branch = 1'b0, flush = 1'b0;
  logic [2:0] in_alu_op = '0;
  logic exm_valid = 1'b0, mwb_valid = 1'b0;
  logic [4:0] exm_rd = '0, mwb_rd = '0;
  logic [31:0] exm_data = '0, mwb_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] alu_a, alu_b, out_rs2_val;
  logic [2:0] alu_op;
  logic [4:0] out_rd;
  logic out_reg_write, out_is_branch;
  int checks = 0, errors = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_is_branch(in_is_branch), .flush(flush),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_valid(mwb_valid), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_branch(out_is_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2,
                      input logic [31:0] d2, input logic [31:0] imm, input logic ui,
                      input logic [2:0] op, input logic [4:0] rd, input logic br);
    in_valid = 1'b1;
    in_rs1 = r1; in_rs1_data = d1; in_rs2 = r2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = ui; in_alu_op = op; in_rd = rd;
    in_reg_write = 1'b1; in_is_branch = br;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    // ADD r3 = r1(5) + r2(7)
    send(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 3'b010, 5'd3, 1'b0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_op", 32'(alu_op), 32'd2);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_rw", 32'(out_reg_write), 32'd1);
    // EX/MEM beats MEM/WB on the same register
    exm_valid = 1'b1; exm_rd = 5'd1; exm_data = 32'h100;
    mwb_valid = 1'b1; mwb_rd = 5'd1; mwb_data = 32'h200;
    #1 chk("fwd_exm_prio", alu_a, 32'h100);
    exm_valid = 1'b0;
    #1 chk("fwd_mwb", alu_a, 32'h200);
    mwb_valid = 1'b0;
    #1 chk("fwd_none", alu_a, 32'd5);
    // back-to-back replace with a SUB reading x0
    out_ready = 1'b1;
    send(5'd0, 32'd0, 5'd2, 32'd7, 32'd0, 1'b0, 3'b110, 5'd4, 1'b0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    exm_valid = 1'b1; exm_rd = 5'd0; exm_data = 32'hDEAD;
    mwb_valid = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hBEEF;
    #1;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(alu_op), 32'd6);
    chk("x0_a", alu_a, 32'd0);
    exm_valid = 1'b0; mwb_valid = 1'b0;
    // three-cycle stall; MEM/WB r2 = 0x42 only in the first
    mwb_valid = 1'b1; mwb_rd = 5'd2; mwb_data = 32'h42;
    #1;
    chk("stall1_b", alu_b, 32'h42);
    chk("stall1_rdy", 32'(in_ready), 32'd0);
    tick();
    mwb_valid = 1'b0; mwb_data = 32'h0;
    #1;
    chk("stall2_b", alu_b, 32'h42);
    chk("stall2_rdy", 32'(in_ready), 32'd0);
    chk("stall2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("stall3_b", alu_b, 32'h42);
    chk("stall3_rdy", 32'(in_ready), 32'd0);
    // immediate operand, store data still rs2
    out_ready = 1'b1;
    send(5'd1, 32'd5, 5'd2, 32'd9, 32'hFFFF_FFFC, 1'b1, 3'b001, 5'd6, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("imm_b", alu_b, 32'hFFFF_FFFC);
    chk("imm_rs2", out_rs2_val, 32'd9);
    chk("imm_op", 32'(alu_op), 32'd1);
    chk("imm_br", 32'(out_is_branch), 32'd1);
    // flush drops both held and incoming
    out_ready = 1'b1; flush = 1'b1;
    send(5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 3'b010, 5'd7, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_rdy", 32'(in_ready), 32'd1);
    // four-instruction stream at full rate
    for (int i = 1; i <= 4; i++) begin
      send(5'd5, 32'(10 * i), 5'd6, 32'd0, 32'd0, 1'b0, 3'b010, 5'd8, 1'b0);
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_a", i), alu_a, 32'(10 * i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(out_valid), 32'd0);
    // reset while stalled discards the instruction
    send(5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 3'b110, 5'd9, 1'b0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_a", alu_a, 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
